// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared types and constants for the data-memory responder slice.
//   - dmemState_e : responder FSM states (idle, wait-state busy, response)
//   - DMEM_MASK_* : lane-positioned byte / half / word write masks
//   - lane_low_mask() : bits that sit below a given byte lane, used to spot a
//     write mask that would spill past the start of the addressed lane
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmemState_e;

    localparam logic [31:0] DMEM_MASK_B0 = 32'h0000_00FF;
    localparam logic [31:0] DMEM_MASK_B1 = 32'h0000_FF00;
    localparam logic [31:0] DMEM_MASK_B2 = 32'h00FF_0000;
    localparam logic [31:0] DMEM_MASK_B3 = 32'hFF00_0000;
    localparam logic [31:0] DMEM_MASK_H0 = 32'h0000_FFFF;
    localparam logic [31:0] DMEM_MASK_H1 = 32'hFFFF_0000;
    localparam logic [31:0] DMEM_MASK_W  = 32'hFFFF_FFFF;

    // Every mask bit below byte lane 'lane' belongs to a lower address than
    // the one the request names, so a store touching them is misaligned.
    function automatic logic [31:0] lane_low_mask(input logic [1:0] lane);
        case (lane)
            2'd0:    return 32'h0000_0000;
            2'd1:    return DMEM_MASK_B0;
            2'd2:    return DMEM_MASK_H0;
            default: return DMEM_MASK_H0 | DMEM_MASK_B2;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Single-port 32-bit word array with a per-bit masked synchronous write
//   and a synchronous read. Contents are never reset.
// Ports:
//   clk        in   clock, rising edge
//   en         in   perform an access this edge (read, plus write if wr_en)
//   wr_en      in   commit a masked write this edge
//   idx        in   word index
//   bit_wr_en  in   per-bit write mask
//   wr_data    in   write data
//   rd_data    out  word read at the last enabled edge (pre-write value)
module dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      bit_wr_en,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // One enabled edge does the whole access: the read register captures the
    // current word and, for stores, only the masked bits take the new data.
    // rd_data holds between accesses so the responder can keep presenting it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wr_en) begin
                mem[idx] <= (mem[idx] & ~bit_wr_en) | (wr_data & bit_wr_en);
            end
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder at the far end of the LSU memory port. Takes one
//   load/store at a time over a valid/ready handshake, inserts WAIT_STATES
//   busy cycles, then performs the access and pulses rsp_valid for a cycle.
//   Loads return the addressed byte/half right-justified.
// Configuration macro:
//   DMEM_RANGE_CHECK_EN  when defined, out-of-range addresses and masks that
//                        reach below the addressed lane raise rsp_err and
//                        suppress the store; otherwise addresses wrap and
//                        rsp_err stays 0.
// Ports:
//   clk, rst         clock (rising) and asynchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_wr_en        1 = store, 0 = load
//   req_bit_wr_en    per-bit store mask (ignored for loads)
//   req_addr         byte address
//   req_wr_data      lane-positioned store data
//   rsp_valid        one-cycle response pulse
//   rsp_rd_data      right-justified load data, 0 for stores and faults
//   rsp_err          access fault, valid with rsp_valid
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr_en,
    input  logic [31:0] req_bit_wr_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    dmemState_e       state;
    logic [3:0]       wait_cnt;
    logic             lat_wr_en;
    logic [31:0]      lat_mask;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic             rd_keep;
    logic [4:0]       rd_shift;

    logic             acc_wr_en;
    logic [31:0]      acc_mask;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             enter_resp;
    logic             fault;
    logic [31:0]      arr_rd_data;

    // With no wait states the access happens on the accepting edge itself,
    // so the live request is used in IDLE and the latched copy afterwards.
    assign acc_wr_en = (state == DMEM_IDLE) ? req_wr_en     : lat_wr_en;
    assign acc_mask  = (state == DMEM_IDLE) ? req_bit_wr_en : lat_mask;
    assign acc_addr  = (state == DMEM_IDLE) ? req_addr      : lat_addr;
    assign acc_wdata = (state == DMEM_IDLE) ? req_wr_data   : lat_wdata;

    assign enter_resp = ((state == DMEM_IDLE) && req_valid && NO_WAIT) ||
                        ((state == DMEM_BUSY) && (wait_cnt == 4'd0));

    // BASE_ADDR is aligned to the array size, so subtracting it never
    // changes the index bits; higher bits simply fall away and wrap.
    assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN_END = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    logic range_fault;
    logic align_fault;

    assign range_fault = (acc_addr < BASE_ADDR) || ({1'b0, acc_addr} >= SPAN_END);
    assign align_fault = acc_wr_en && ((acc_mask & lane_low_mask(acc_addr[1:0])) != 32'h0);
    assign fault       = range_fault || align_fault;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{acc_addr[31:IDX_W+2], BASE_ADDR};
    assign fault            = 1'b0;
`endif

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk       (clk),
        .en        (enter_resp),
        .wr_en     (enter_resp && acc_wr_en && !fault),
        .idx       (acc_idx),
        .bit_wr_en (acc_mask),
        .wr_data   (acc_wdata),
        .rd_data   (arr_rd_data)
    );

    // Responder FSM. IDLE latches the request so the requester may drop it
    // right away; BUSY counts down the wait states; RESP is the single
    // response cycle. The response flags are loaded on the same edge that
    // the array is accessed, and are otherwise left alone so they hold
    // until the next response. A reset during BUSY leaves the array
    // untouched because the commit only ever happens entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DMEM_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            wait_cnt  <= 4'd0;
            rd_keep   <= 1'b0;
            rd_shift  <= 5'd0;
            lat_wr_en <= 1'b0;
            lat_mask  <= 32'h0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        lat_wr_en <= req_wr_en;
                        lat_mask  <= req_bit_wr_en;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wr_data;
                        wait_cnt  <= WAIT_LOAD;
                        req_ready <= 1'b0;
                        state     <= NO_WAIT ? DMEM_RESP : DMEM_BUSY;
                    end
                end
                DMEM_BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        state <= DMEM_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DMEM_RESP: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= fault;
                rd_keep   <= !acc_wr_en && !fault;
                rd_shift  <= {acc_addr[1:0], 3'b000};
            end
        end
    end

    // Only a good load exposes array data; stores and faults read as zero.
    assign rsp_rd_data = rd_keep ? (arr_rd_data >> rd_shift) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. A WAIT_STATES=3 instance carries
//   the table, reset-abort, wrap/range and randomized traffic; a second
//   WAIT_STATES=0 instance covers back-to-back requests with req_valid held.
//   Expected values come from constants and a word-array reference model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          DEPTH   = 64;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int          WS      = 3;
    localparam int          TIMEOUT = 40;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit CHECKS_ON = 1'b1;
`else
    localparam bit CHECKS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr_en, rsp_valid, rsp_err;
    logic [31:0] req_bit_wr_en, req_addr, req_wr_data, rsp_rd_data;
    logic        b_req_valid, b_req_ready, b_req_wr_en, b_rsp_valid, b_rsp_err;
    logic [31:0] b_req_bit_wr_en, b_req_addr, b_req_wr_data, b_rsp_rd_data;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    logic        got_ready_low;
    logic        got_pulse_ok;

    typedef struct {
        logic        wr;
        logic [31:0] mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr_en(req_wr_en),
        .req_bit_wr_en(req_bit_wr_en), .req_addr(req_addr), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr_en(b_req_wr_en),
        .req_bit_wr_en(b_req_bit_wr_en), .req_addr(b_req_addr), .req_wr_data(b_req_wr_data),
        .rsp_valid(b_rsp_valid), .rsp_rd_data(b_rsp_rd_data), .rsp_err(b_rsp_err)
    );

    always #5 clk = ~clk;

    // Safety net so a wedged run still ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model: the word array addressed by plain byte arithmetic.
    function automatic int model_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    function automatic logic model_fault(input logic wr, input logic [31:0] mask, input logic [31:0] addr);
        longint unsigned a, lo, hi;
        int lane;
        logic f;
        a    = 64'(addr);
        lo   = 64'(BASE);
        hi   = 64'(BASE) + 64'(4 * DEPTH);
        lane = int'(addr % 4);
        f    = (a < lo) || (a >= hi);
        if (wr) begin
            for (int b = 0; b < 8 * lane; b++) begin
                if (mask[b]) f = 1'b1;
            end
        end
        return CHECKS_ON && f;
    endfunction

    task automatic model_access(input logic wr, input logic [31:0] mask, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = model_index(addr);
        exp_err = model_fault(wr, mask, addr);
        if (wr) begin
            exp_rd = 32'h0;
            if (!exp_err) begin
                for (int b = 0; b < 32; b++) begin
                    if (mask[b]) model_mem[idx][b] = wdata[b];
                end
            end
        end else begin
            exp_rd = exp_err ? 32'h0 : (model_mem[idx] >> (8 * (addr % 4)));
        end
    endtask

    // One request on the main instance, called and returning at a negedge.
    // Inputs are scrambled right after acceptance; latency is counted in
    // negedges after the handshake cycle.
    task automatic applyStimulus(input logic wr, input logic [31:0] mask, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        int n;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_wr_en = wr; req_bit_wr_en = mask; req_addr = addr; req_wr_data = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_wr_en = 1'($urandom); req_bit_wr_en = $urandom;
        req_addr = $urandom; req_wr_data = $urandom;
        got_ready_low = 1'b1;
        n = 1;
        while (!rsp_valid && n < TIMEOUT) begin
            if (req_ready) got_ready_low = 1'b0;
            @(negedge clk);
            n++;
        end
        if (req_ready) got_ready_low = 1'b0;
        got_lat = n;
        got_rd  = rsp_rd_data;
        got_err = rsp_err;
        @(negedge clk);
        got_pulse_ok = !rsp_valid && req_ready;
    endtask

    task automatic checkAccess(input string name, input logic wr, input logic [31:0] mask,
                               input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        model_access(wr, mask, addr, wdata, exp_rd, exp_err);
        applyStimulus(wr, mask, addr, wdata);
        checkOutput({name, "_rd"}, got_rd, exp_rd);
        checkOutput({name, "_err"}, 32'(got_err), 32'(exp_err));
        checkOutput({name, "_lat"}, 32'(got_lat), 32'(WS + 1));
        checkOutput({name, "_ready"}, {30'b0, got_ready_low, got_pulse_ok}, 32'd3);
    endtask

    task automatic bStore(input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        while (!b_req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        b_req_valid = 1'b1; b_req_wr_en = 1'b1; b_req_bit_wr_en = DMEM_MASK_W;
        b_req_addr = addr; b_req_wr_data = data;
        @(negedge clk);
        b_req_valid = 1'b0;
        n = 1;
        while (!b_rsp_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b_store_lat", 32'(n), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] b_words [4];
        logic [31:0] b_addrs [4];
        int          pulse_cycle [4];
        logic [31:0] pulse_data [4];
        int          pulses, sent, cyc;
        logic        refused_ok, saw_rsp, accept;

        rst = 1'b1;
        req_valid = 1'b0; req_wr_en = 1'b0; req_bit_wr_en = '0; req_addr = '0; req_wr_data = '0;
        b_req_valid = 1'b0; b_req_wr_en = 1'b0; b_req_bit_wr_en = '0; b_req_addr = '0; b_req_wr_data = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rd_data", rsp_rd_data, 32'h0);
        checkOutput("reset_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_b_ready", 32'(b_req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            checkAccess("init", 1'b1, DMEM_MASK_W, BASE + 32'(4 * i), $urandom);
        end

        vecs.push_back('{1'b1, 32'hFFFF_FFFF, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h00FF_0000, BASE + 32'h12, 32'h00AB_0000, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h12, 32'h0,         32'h0000_DEAB, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h10, 32'h0,         32'hDEAB_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h13, 32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b1, 32'h0,         BASE + 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h10, 32'h0,         32'hDEAB_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_0000, BASE + 32'h12, 32'h1234_0000, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h10, 32'h0,         32'h1234_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0,         BASE + 32'h11, 32'h0,         32'h0012_34BE, 1'b0});
        foreach (vecs[i]) begin
            logic [31:0] m_rd;
            logic        m_err;
            model_access(vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].wdata, m_rd, m_err);
            applyStimulus(vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_rd", i), got_rd, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_lat", i), 32'(got_lat), 32'(WS + 1));
        end

        // Reset while a store is waiting in BUSY: no response, no commit.
        req_valid = 1'b1; req_wr_en = 1'b1; req_bit_wr_en = DMEM_MASK_W;
        req_addr = BASE + 32'h10; req_wr_data = 32'h1111_1111;
        @(negedge clk);
        req_valid = 1'b0;
        saw_rsp = rsp_valid;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_rd_data", rsp_rd_data, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_rsp |= rsp_valid;
            @(negedge clk);
        end
        checkOutput("abort_no_rsp", 32'(saw_rsp), 32'd0);
        checkAccess("abort_reload", 1'b0, 32'h0, BASE + 32'h10, 32'h0);
        checkOutput("abort_old_word", got_rd, 32'h1234_BEEF);

        // One past the end: faults with checks enabled, wraps to word 0 without.
        checkAccess("wrap_seed", 1'b1, DMEM_MASK_W, BASE, 32'h55AA_55AA);
        checkAccess("wrap_store", 1'b1, DMEM_MASK_W, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D);
        checkOutput("wrap_store_err", 32'(got_err), 32'(CHECKS_ON));
        checkAccess("wrap_load", 1'b0, 32'h0, BASE, 32'h0);
        checkOutput("wrap_word0", got_rd, CHECKS_ON ? 32'h55AA_55AA : 32'hCAFE_F00D);

        for (int i = 0; i < 150; i++) begin
            logic        wr;
            logic [31:0] addr, mask;
            int          r, lane;
            wr = 1'($urandom);
            r  = $urandom_range(0, 9);
            if (r < 8)       addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (r == 8) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else             addr = BASE - 32'd1 - 32'($urandom_range(0, 255));
            lane = int'(addr % 4);
            mask = 32'h0;
            if (wr) begin
                case ($urandom_range(0, 3))
                    0: case (lane)
                           0: mask = DMEM_MASK_B0;
                           1: mask = DMEM_MASK_B1;
                           2: mask = DMEM_MASK_B2;
                           default: mask = DMEM_MASK_B3;
                       endcase
                    1: mask = (lane < 2) ? DMEM_MASK_H0 : DMEM_MASK_H1;
                    2: mask = DMEM_MASK_W;
                    default: mask = $urandom;
                endcase
            end
            checkAccess("rand", wr, mask, addr, $urandom);
        end

        // Back-to-back loads on the zero-wait instance with req_valid held.
        for (int i = 0; i < 4; i++) begin
            b_words[i] = $urandom;
            b_addrs[i] = BASE + 32'(5 * i);
            bStore(BASE + 32'(4 * i), b_words[i]);
        end
        pulses = 0; sent = 0; refused_ok = 1'b1;
        b_req_wr_en = 1'b0; b_req_bit_wr_en = 32'h0; b_req_addr = b_addrs[0]; b_req_valid = 1'b1;
        for (cyc = 0; cyc < 20 && pulses < 4; cyc++) begin
            if (b_rsp_valid) begin
                if (pulses < 4) begin
                    pulse_cycle[pulses] = cyc;
                    pulse_data[pulses]  = b_rsp_rd_data;
                end
                pulses++;
                if (b_req_ready) refused_ok = 1'b0;
            end
            accept = b_req_valid && b_req_ready;
            @(posedge clk);
            #1;
            if (accept) begin
                sent++;
                if (sent == 4) b_req_valid = 1'b0;
                else           b_req_addr  = b_addrs[sent];
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        checkOutput("b2b_pulses", 32'(pulses), 32'd4);
        checkOutput("b2b_resp_not_ready", 32'(refused_ok), 32'd1);
        if (pulses >= 4) begin
            checkOutput("b2b_first_lat", 32'(pulse_cycle[0]), 32'd1);
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("b2b_data%0d", i), pulse_data[i], b_words[i] >> (8 * i));
                if (i > 0) checkOutput($sformatf("b2b_gap%0d", i), 32'(pulse_cycle[i] - pulse_cycle[i-1]), 32'd2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
